p2p_reg_arbiter: RTL and testbench

Shares one single-port register memory between the system AXI-lite register path and NUM_RD internal read requesters in the p2p plugin. The system path (read or write) normally has priority. Internal reads are served round-robin, with a starvation guard that forces an internal grant. Accepted requests are issued through a fixed-latency, in-order pipeline, and each response is returned to the originating requester.

---
 rtl/p2p_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_p2p_reg_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2p_reg_arbiter.sv
// p2p_reg_arbiter: shares one single-port register RAM between the system
// AXI-lite path and NUM_RD internal readers through a fixed-latency pipe.
module p2p_reg_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_RD       = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         axil_aclk,
   input  logic                         axil_aresetn,
   input  logic                         sys_req_valid,
   output logic                         sys_req_ready,
   input  logic                         sys_req_we,
   input  logic [ADDR_WIDTH-1:0]        sys_req_addr,
   input  logic [DATA_WIDTH-1:0]        sys_req_din,
   output logic                         sys_rsp_valid,
   output logic [DATA_WIDTH-1:0]        sys_rsp_data,
   input  logic [NUM_RD-1:0]            rd_req_valid,
   output logic [NUM_RD-1:0]            rd_req_ready,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr,
   output logic [NUM_RD-1:0]            rd_rsp_valid,
   output logic [DATA_WIDTH-1:0]        rd_rsp_data,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [DATA_WIDTH-1:0]        mem_din,
   input  logic [DATA_WIDTH-1:0]        mem_dout
);
   localparam int IW = $clog2(NUM_RD);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [IW:0]   NRD  = (IW+1)'(NUM_RD);
   localparam logic [IW-1:0] LAST = IW'(NUM_RD - 1);
   localparam logic [CW-1:0] LIM  = CW'(STARVE_LIMIT);

   typedef struct packed {
      logic          v;
      logic          we;
      logic          sys;
      logic [IW-1:0] idx;
   } tag_t;

   logic [IW-1:0]         rr_q, rr_d;
   logic [CW-1:0]         starve_q, starve_d;
   tag_t                  t1_q, t1_d, t2_q;
   logic                  en_q, we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic                  srv_q;
   logic [DATA_WIDTH-1:0] srd_q, rrd_q;
   logic [NUM_RD-1:0]     rrv_q;

   logic                  any_rd, force_rd, grant_sys, grant_rd, rd_hit;
   logic [IW-1:0]         rd_sel;
   logic [IW:0]           scan;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Round-robin scan starting at rr_q, wrapping at NUM_RD.
   always_comb begin
      rd_hit = 1'b0;
      rd_sel = '0;
      scan   = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         scan = {1'b0, rr_q} + (IW+1)'(k);
         if (scan >= NRD) scan = scan - NRD;
         if (!rd_hit && rd_req_valid[scan[IW-1:0]]) begin
            rd_hit = 1'b1;
            rd_sel = scan[IW-1:0];
         end
      end
   end

   always_comb begin
      rd_addr = '0;
      for (int k = 0; k < NUM_RD; k++)
         if (rd_sel == IW'(k)) rd_addr = rd_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
   end

   assign any_rd        = |rd_req_valid;
   assign force_rd      = any_rd && (starve_q == LIM);
   assign grant_sys     = axil_aresetn && sys_req_valid && !force_rd;
   assign grant_rd      = axil_aresetn && rd_hit && (force_rd || !sys_req_valid);
   assign sys_req_ready = grant_sys;
   assign rd_req_ready  = grant_rd ? (NUM_RD'(1) << rd_sel) : '0;

   always_comb begin
      rr_d = rr_q;
      if (grant_rd) rr_d = (rd_sel == LAST) ? '0 : rd_sel + 1'b1;
      starve_d = starve_q;
      if (!any_rd || grant_rd) starve_d = '0;
      else if (starve_q != LIM) starve_d = starve_q + 1'b1;
      t1_d.v   = grant_sys || grant_rd;
      t1_d.we  = grant_sys && sys_req_we;
      t1_d.sys = grant_sys;
      t1_d.idx = rd_sel;
   end

   // t1 follows the issue stage, t2 lines up with mem_dout.
   always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
      if (!axil_aresetn) begin
         rr_q     <= '0;
         starve_q <= '0;
         t1_q     <= '0;
         t2_q     <= '0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         srv_q    <= 1'b0;
         srd_q    <= '0;
         rrv_q    <= '0;
         rrd_q    <= '0;
      end else begin
         rr_q     <= rr_d;
         starve_q <= starve_d;
         t1_q     <= t1_d;
         t2_q     <= t1_q;
         en_q     <= t1_d.v;
         we_q     <= t1_d.we;
         if (grant_sys) begin
            addr_q <= sys_req_addr;
            din_q  <= sys_req_we ? sys_req_din : '0;
         end else if (grant_rd) begin
            addr_q <= rd_addr;
            din_q  <= '0;
         end
         srv_q <= t2_q.v && t2_q.sys;
         rrv_q <= (t2_q.v && !t2_q.sys) ? (NUM_RD'(1) << t2_q.idx) : '0;
         if (t2_q.v && t2_q.sys) srd_q <= t2_q.we ? '0 : mem_dout;
         if (t2_q.v && !t2_q.sys) rrd_q <= mem_dout;
      end
   end

   assign mem_en        = en_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_din       = din_q;
   assign sys_rsp_valid = srv_q;
   assign sys_rsp_data  = srd_q;
   assign rd_rsp_valid  = rrv_q;
   assign rd_rsp_data   = rrd_q;

endmodule

// File: tb/tb_p2p_reg_arbiter.sv
// tb_p2p_reg_arbiter: vector table, directed corner sequences and random
// traffic compared against a transaction-level reference model.
module tb_p2p_reg_arbiter;
   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int NR  = 4;
   localparam int LIM = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic sys_v, sys_we, sys_rdy, sys_rv;
   logic [AW-1:0] sys_addr;
   logic [DW-1:0] sys_din, sys_rd, rd_rd;
   logic [NR-1:0] rd_v, rd_rdy, rd_rv;
   logic [NR*AW-1:0] rd_addr;
   logic mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;
   logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
   logic [DW-1:0] refmem [0:(1<<AW)-1] = '{default: '0};

   always #5 clk = ~clk;

   p2p_reg_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .STARVE_LIMIT(LIM)
   ) dut (
      .axil_aclk(clk), .axil_aresetn(rst_n),
      .sys_req_valid(sys_v), .sys_req_ready(sys_rdy), .sys_req_we(sys_we),
      .sys_req_addr(sys_addr), .sys_req_din(sys_din),
      .sys_rsp_valid(sys_rv), .sys_rsp_data(sys_rd),
      .rd_req_valid(rd_v), .rd_req_ready(rd_rdy), .rd_req_addr(rd_addr),
      .rd_rsp_valid(rd_rv), .rd_rsp_data(rd_rd),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_din;
         else mem_dout <= ram[mem_addr];
      end

   typedef struct {
      int            due;
      bit            sys;
      int            idx;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      bit            sv;
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NR-1:0] rv;
      bit            x_s;
      logic [NR-1:0] x_r;
   } vec_t;

   exp_t expq[$];
   vec_t tbl[12];
   int cyc, m_rr, m_starve, total, passes;
   bit m_acc, m_we;
   logic obs_srdy, obs_srv, obs_en;
   logic [NR-1:0] obs_rrdy, obs_rrv;
   logic [DW-1:0] obs_sd, obs_rd;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic model_reset();
      expq.delete();
      m_rr = 0;
      m_starve = 0;
      m_acc = 0;
      m_we = 0;
   endtask

   // Called mid-cycle: checks this cycle, then advances the model one edge.
   task automatic check_cycle();
      bit any, frc, gs, ev_s;
      int gi;
      logic [NR-1:0] x_r, ev_r;
      logic [DW-1:0] ed;
      exp_t e;
      obs_srdy = sys_rdy; obs_rrdy = rd_rdy; obs_en = mem_en;
      obs_srv = sys_rv; obs_rrv = rd_rv; obs_sd = sys_rd; obs_rd = rd_rd;
      any = |rd_v;
      frc = any && (m_starve == LIM);
      gs  = sys_v && !frc;
      gi  = -1;
      if (!gs)
         for (int k = 0; k < NR; k++)
            if (gi < 0 && rd_v[(m_rr + k) % NR]) gi = (m_rr + k) % NR;
      x_r = (gi >= 0) ? NR'(1 << gi) : '0;
      chk("sys_ready", 32'(sys_rdy), 32'(gs));
      chk("rd_ready", 32'(rd_rdy), 32'(x_r));
      chk("mem_en", 32'(mem_en), 32'(m_acc));
      chk("mem_we", 32'(mem_we), 32'(m_acc && m_we));
      ev_s = 0; ev_r = '0; ed = '0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         e = expq.pop_front();
         ed = e.data;
         if (e.sys) ev_s = 1;
         else ev_r = NR'(1 << e.idx);
      end
      chk("sys_rsp_valid", 32'(sys_rv), 32'(ev_s));
      chk("rd_rsp_valid", 32'(rd_rv), 32'(ev_r));
      if (ev_s) chk("sys_rsp_data", sys_rd, ed);
      if (|ev_r) chk("rd_rsp_data", rd_rd, ed);
      m_acc = gs || (gi >= 0);
      m_we  = gs && sys_we;
      if (gs) begin
         expq.push_back('{cyc + 3, 1'b1, 0, sys_we ? '0 : refmem[sys_addr]});
         if (sys_we) refmem[sys_addr] = sys_din;
      end else if (gi >= 0) begin
         expq.push_back('{cyc + 3, 1'b0, gi, refmem[rd_addr[gi*AW +: AW]]});
         m_rr = (gi + 1) % NR;
      end
      if (!any || gi >= 0) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sys_v = 0; sys_we = 0; sys_addr = '0; sys_din = '0; rd_v = '0;
   endtask

   task automatic sys_req(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      sys_v = 1; sys_we = we; sys_addr = a; sys_din = d;
   endtask

   initial begin
      total = 0; passes = 0; cyc = 0;
      model_reset();
      idle();
      rd_addr = {12'h103, 12'h102, 12'h101, 12'h100};
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_mem_en", 32'(mem_en), 0);
      chk("reset_rsp", 32'({sys_rv, rd_rv}), 0);
      chk("reset_data", sys_rd | rd_rd | mem_din, 0);
      chk("reset_addr", 32'(mem_addr), 0);
      rst_n = 1;

      tbl[0]  = '{0, 0, 12'h000, 32'h0,    4'b1111, 0, 4'b0001};
      tbl[1]  = '{0, 0, 12'h000, 32'h0,    4'b1111, 0, 4'b0010};
      tbl[2]  = '{0, 0, 12'h000, 32'h0,    4'b1111, 0, 4'b0100};
      tbl[3]  = '{0, 0, 12'h000, 32'h0,    4'b1111, 0, 4'b1000};
      tbl[4]  = '{0, 0, 12'h000, 32'h0,    4'b1111, 0, 4'b0001};
      tbl[5]  = '{1, 0, 12'h100, 32'h0,    4'b1000, 1, 4'b0000};
      tbl[6]  = '{0, 0, 12'h000, 32'h0,    4'b0001, 0, 4'b0001};
      tbl[7]  = '{0, 0, 12'h000, 32'h0,    4'b0000, 0, 4'b0000};
      tbl[8]  = '{1, 1, 12'h030, 32'h1234, 4'b0000, 1, 4'b0000};
      tbl[9]  = '{0, 0, 12'h000, 32'h0,    4'b0011, 0, 4'b0010};
      tbl[10] = '{0, 0, 12'h000, 32'h0,    4'b0011, 0, 4'b0001};
      tbl[11] = '{1, 0, 12'h030, 32'h0,    4'b0000, 1, 4'b0000};
      for (int i = 0; i < 12; i++) begin
         sys_v = tbl[i].sv; sys_we = tbl[i].we; sys_addr = tbl[i].a;
         sys_din = tbl[i].d; rd_v = tbl[i].rv;
         step();
         chk("tbl_sys_ready", 32'(obs_srdy), 32'(tbl[i].x_s));
         chk("tbl_rd_ready", 32'(obs_rrdy), 32'(tbl[i].x_r));
      end
      idle();
      repeat (4) step();

      sys_req(1, 12'h010, 32'hDEADBEEF);
      step();
      sys_req(0, 12'h010, 32'h0);
      step();
      chk("basic_en_n1", 32'(obs_en), 1);
      idle();
      step();
      chk("basic_en_n2", 32'(obs_en), 1);
      step();
      chk("basic_wr_rsp", 32'(obs_srv), 1);
      chk("basic_wr_data", obs_sd, 0);
      step();
      chk("basic_rd_rsp", 32'(obs_srv), 1);
      chk("basic_rd_data", obs_sd, 32'hDEADBEEF);
      step();

      sys_req(1, 12'h020, 32'h55);
      step();
      idle();
      rd_v = 4'b0010;
      rd_addr[1*AW +: AW] = 12'h020;
      step();
      chk("raw_grant", 32'(obs_rrdy), 32'(4'b0010));
      rd_v = '0;
      step();
      step();
      step();
      chk("raw_rsp_valid", 32'(obs_rrv), 32'(4'b0010));
      chk("raw_rsp_data", obs_rd, 32'h55);
      step();

      idle();
      repeat (20) begin
         step();
         chk("idle_en", 32'(obs_en), 0);
         chk("idle_ready", 32'({obs_srdy, obs_rrdy}), 0);
         chk("idle_rsp", 32'({obs_srv, obs_rrv}), 0);
      end

      sys_req(0, 12'h005, 32'h0);
      rd_v = 4'b0100;
      rd_addr[2*AW +: AW] = 12'h007;
      for (int k = 0; k < 18; k++) begin
         step();
         chk("starve_sys", 32'(obs_srdy), 32'((k % 9) != 8));
         chk("starve_rd", 32'(obs_rrdy), ((k % 9) == 8) ? 32'h4 : 32'h0);
      end
      idle();
      repeat (4) step();

      rd_v = 4'b0111;
      rd_addr = {12'h000, 12'h012, 12'h011, 12'h010};
      step();
      step();
      @(negedge clk);
      check_cycle();
      chk("flight_third_grant", 32'(|obs_rrdy), 1);
      #3 rst_n = 0;
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 32'({sys_rdy, rd_rdy}), 0);
         chk("rst_mem_en", 32'({mem_en, mem_we}), 0);
         chk("rst_rsp", 32'({sys_rv, rd_rv}), 0);
      end
      @(posedge clk);
      #1 rst_n = 1;
      idle();
      repeat (5) begin
         step();
         chk("post_rst_rsp", 32'({obs_srv, obs_rrv}), 0);
         chk("post_rst_en", 32'(obs_en), 0);
      end
      rd_v = 4'b1111;
      step();
      chk("rr_after_reset", 32'(obs_rrdy), 32'(4'b0001));
      idle();
      repeat (4) step();

      for (int n = 0; n < 500; n++) begin
         sys_v    = 1'($urandom_range(0, 1));
         sys_we   = 1'($urandom_range(0, 1));
         sys_addr = AW'($urandom_range(0, 15));
         sys_din  = $urandom;
         rd_v     = NR'($urandom);
         for (int k = 0; k < NR; k++)
            rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
         step();
      end
      idle();
      repeat (5) step();
      chk("drain_empty", 32'(expq.size()), 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
